// File: rtl/lcd_spi_write_if.sv
// rtl/lcd_spi_write_if.sv - word handshake between the LCD word source and the SPI writer
//
// Purpose: carries one 9-bit LCD word and its write request from the upstream
// sequencer to lcd_spi_write, and the completion/busy status back.
// Signals:
//   data     [8]=D/C (0 command, 1 data), [7:0] payload byte, MSB sent first
//   en_write upstream has a valid word (level)
//   wr_done  one-cycle pulse when the word is fully shifted and CS released
//   busy     writer is not idle
// Modports: master = word source, slave = SPI writer.
interface lcd_spi_write_if;
    logic [8:0] data;
    logic       en_write;
    logic       wr_done;
    logic       busy;

    modport master (output data, output en_write, input wr_done, input busy);
    modport slave  (input data, input en_write, output wr_done, output busy);
endinterface

// File: rtl/lcd_spi_write.sv
// rtl/lcd_spi_write.sv - serialises one 9-bit LCD word per handshake onto a 4-wire SPI bus
//
// Purpose: sends one command/data byte to an ST7789 panel in SPI mode 0,
// holding D/C for the whole word and pulsing wr_done once CS is released.
// Ports:
//   sys_clk_50MHz  system clock, all logic on the rising edge
//   sys_rst        synchronous active-high reset
//   wr_if          word handshake (slave side): data, en_write in; wr_done, busy out
//   lcd_cs         chip select, active low
//   lcd_dc         data/command select, stable while CS is low
//   lcd_sclk       SPI clock, idle low
//   lcd_mosi       SPI data, changes on SCLK falling edges or at word start
// Parameters:
//   CLK_DIV        SCLK half-period in system clocks (>=1)
//   GAP_CYCLES     idle cycles after wr_done before en_write is sampled again (>=2)
module lcd_spi_write #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic            sys_clk_50MHz,
    input  logic            sys_rst,
    lcd_spi_write_if.slave  wr_if,
    output logic            lcd_cs,
    output logic            lcd_dc,
    output logic            lcd_sclk,
    output logic            lcd_mosi
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_END,
        S_GAP
    } state_t;

    state_t           r_state;
    logic [7:0]       r_shift;
    logic [2:0]       r_bit_cnt;
    logic [DIV_W-1:0] r_div_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic             r_cs;
    logic             r_dc;
    logic             r_sclk;
    logic             r_mosi;
    logic             r_wr_done;
    logic             r_busy;

    state_t           w_state;
    logic [7:0]       w_shift;
    logic [2:0]       w_bit_cnt;
    logic [DIV_W-1:0] w_div_cnt;
    logic [GAP_W-1:0] w_gap_cnt;
    logic             w_cs;
    logic             w_dc;
    logic             w_sclk;
    logic             w_mosi;
    logic             w_wr_done;
    logic             w_busy;
    logic             w_div_last;

    always_ff @(posedge sys_clk_50MHz) begin
        if (sys_rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_gap_cnt <= '0;
            r_cs      <= 1'b1;
            r_dc      <= 1'b0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_wr_done <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_bit_cnt <= w_bit_cnt;
            r_div_cnt <= w_div_cnt;
            r_gap_cnt <= w_gap_cnt;
            r_cs      <= w_cs;
            r_dc      <= w_dc;
            r_sclk    <= w_sclk;
            r_mosi    <= w_mosi;
            r_wr_done <= w_wr_done;
            r_busy    <= w_busy;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_bit_cnt  = r_bit_cnt;
        w_div_cnt  = r_div_cnt;
        w_gap_cnt  = r_gap_cnt;
        w_cs       = r_cs;
        w_dc       = r_dc;
        w_sclk     = r_sclk;
        w_mosi     = r_mosi;
        w_wr_done  = 1'b0;
        w_div_last = (r_div_cnt == DIV_LAST);

        case (r_state)
            S_IDLE: begin
                w_cs   = 1'b1;
                w_sclk = 1'b0;
                if (wr_if.en_write) begin
                    // First bit goes out together with CS so it is set up
                    // a full half-period before the first rising SCLK edge.
                    w_shift   = wr_if.data[7:0];
                    w_dc      = wr_if.data[8];
                    w_mosi    = wr_if.data[7];
                    w_cs      = 1'b0;
                    w_bit_cnt = '0;
                    w_div_cnt = '0;
                    w_state   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (w_div_last) begin
                    w_div_cnt = '0;
                    w_sclk    = ~r_sclk;
                    // r_sclk high here means this toggle is a falling edge.
                    if (r_sclk) begin
                        if (r_bit_cnt == 3'd7) begin
                            w_state = S_END;
                        end else begin
                            w_bit_cnt = r_bit_cnt + 3'd1;
                            w_mosi    = r_shift[6];
                            w_shift   = {r_shift[6:0], 1'b0};
                        end
                    end
                end else begin
                    w_div_cnt = r_div_cnt + 1'b1;
                end
            end

            S_END: begin
                // CS hold time: SCLK low, CS low for one more half-period.
                if (w_div_last) begin
                    w_div_cnt = '0;
                    w_cs      = 1'b1;
                    w_wr_done = 1'b1;
                    w_mosi    = 1'b0;
                    w_gap_cnt = '0;
                    w_state   = S_GAP;
                end else begin
                    w_div_cnt = r_div_cnt + 1'b1;
                end
            end

            S_GAP: begin
                // Lets the upstream advance its index and register the next
                // word before en_write is looked at again.
                if (r_gap_cnt == GAP_LAST) begin
                    w_gap_cnt = '0;
                    w_state   = S_IDLE;
                end else begin
                    w_gap_cnt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state = S_IDLE;
                w_cs    = 1'b1;
                w_sclk  = 1'b0;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    assign wr_if.wr_done = r_wr_done;
    assign wr_if.busy    = r_busy;
    assign lcd_cs        = r_cs;
    assign lcd_dc        = r_dc;
    assign lcd_sclk      = r_sclk;
    assign lcd_mosi      = r_mosi;

endmodule

// File: tb/tb_lcd_spi_write.sv
// tb/tb_lcd_spi_write.sv - directed self-checking bench for lcd_spi_write
module tb_lcd_spi_write;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    // ---------------- DUT A: default parameters ----------------
    lcd_spi_write_if ifa ();
    logic       a_cs, a_dc, a_sclk, a_mosi;
    logic [8:0] drv_data = 9'h000;
    logic       drv_en   = 1'b0;

    // Upstream counter model: advances on wr_done, registers the word a cycle later.
    logic       up_mode = 1'b0;
    int         up_idx  = 0;
    logic [8:0] up_word = 9'h000;
    logic       up_en   = 1'b0;

    function automatic logic [8:0] up_tab(int i);
        case (i)
            0:       return 9'h011;
            1:       return 9'h036;
            2:       return 9'h100;
            default: return 9'h000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!up_mode) begin
            up_idx  <= 0;
            up_word <= 9'h000;
            up_en   <= 1'b0;
        end else begin
            if (ifa.wr_done === 1'b1) up_idx <= up_idx + 1;
            up_word <= up_tab(up_idx);
            up_en   <= (up_idx < 3);
        end
    end

    assign ifa.data     = up_mode ? up_word : drv_data;
    assign ifa.en_write = up_mode ? up_en   : drv_en;

    lcd_spi_write #(.CLK_DIV(2), .GAP_CYCLES(2)) u_dut_a (
        .sys_clk_50MHz (clk),
        .sys_rst       (rst),
        .wr_if         (ifa),
        .lcd_cs        (a_cs),
        .lcd_dc        (a_dc),
        .lcd_sclk      (a_sclk),
        .lcd_mosi      (a_mosi)
    );

    // ---------------- DUT B: CLK_DIV=1 ----------------
    lcd_spi_write_if ifb ();
    logic       b_cs, b_dc, b_sclk, b_mosi;
    logic [8:0] b_data = 9'h000;
    logic       b_en   = 1'b0;
    assign ifb.data     = b_data;
    assign ifb.en_write = b_en;

    lcd_spi_write #(.CLK_DIV(1), .GAP_CYCLES(2)) u_dut_b (
        .sys_clk_50MHz (clk),
        .sys_rst       (rst),
        .wr_if         (ifb),
        .lcd_cs        (b_cs),
        .lcd_dc        (b_dc),
        .lcd_sclk      (b_sclk),
        .lcd_mosi      (b_mosi)
    );

    // ---------------- bus decoders (sample on the falling clock edge) ----------------
    logic       a_prev_sclk = 1'b0, a_prev_cs = 1'b1, a_rx_dc = 1'b0, a_dc_moved = 1'b0;
    logic [7:0] a_rx_byte = 8'h00;
    int         a_rx_bits = 0, a_fall_cnt = 0, a_done_cnt = 0, a_done_cyc = 0;
    int         a_last_rise = 0, a_period = 0, a_cs_rise_cyc = 0;
    logic [8:0] a_words[$];
    int         a_bits[$];
    int         a_starts[$];

    always @(negedge clk) begin
        if (a_prev_cs && !a_cs) begin
            a_fall_cnt <= a_fall_cnt + 1;
            a_starts.push_back(cyc);
            a_rx_byte  <= 8'h00;
            a_rx_bits  <= 0;
            a_rx_dc    <= a_dc;
        end else if (!a_prev_sclk && a_sclk) begin
            a_rx_byte   <= {a_rx_byte[6:0], a_mosi};
            a_rx_bits   <= a_rx_bits + 1;
            a_period    <= cyc - a_last_rise;
            a_last_rise <= cyc;
        end
        if (!a_prev_cs && !a_cs && (a_dc !== a_rx_dc)) a_dc_moved <= 1'b1;
        if (!a_prev_cs && a_cs) begin
            a_words.push_back({a_rx_dc, a_rx_byte});
            a_bits.push_back(a_rx_bits);
            a_cs_rise_cyc <= cyc;
        end
        if (ifa.wr_done === 1'b1) begin
            a_done_cnt <= a_done_cnt + 1;
            a_done_cyc <= cyc;
        end
        a_prev_sclk <= a_sclk;
        a_prev_cs   <= a_cs;
    end

    logic       b_prev_sclk = 1'b0, b_prev_cs = 1'b1;
    logic [7:0] b_rx = 8'h00;
    int         b_last_rise = 0, b_period = 0, b_done_cnt = 0, b_done_cyc = 0;
    logic [7:0] b_bytes[$];
    int         b_starts[$];

    always @(negedge clk) begin
        if (b_prev_cs && !b_cs) begin
            b_starts.push_back(cyc);
            b_rx <= 8'h00;
        end else if (!b_prev_sclk && b_sclk) begin
            b_rx        <= {b_rx[6:0], b_mosi};
            b_period    <= cyc - b_last_rise;
            b_last_rise <= cyc;
        end
        if (!b_prev_cs && b_cs) b_bytes.push_back(b_rx);
        if (ifb.wr_done === 1'b1) begin
            b_done_cnt <= b_done_cnt + 1;
            b_done_cyc <= cyc;
        end
        b_prev_sclk <= b_sclk;
        b_prev_cs   <= b_cs;
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic step_n(int n);
        repeat (n) step();
    endtask

    task automatic step_to(int c);
        int g = 0;
        while (cyc < c && g < 1000) begin
            step();
            g++;
        end
    endtask

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic a_wait_fall(int base, int bound, string tag);
        int g = 0;
        while (a_fall_cnt == base && g < bound) begin
            step();
            g++;
        end
        check(tag, 32'(a_fall_cnt > base), 32'd1);
    endtask

    task automatic a_wait_done(int base, int bound, string tag);
        int g = 0;
        while (a_done_cnt == base && g < bound) begin
            step();
            g++;
        end
        check(tag, 32'(a_done_cnt > base), 32'd1);
    endtask

    task automatic check_a_idle(string tag);
        check({tag, "_cs"},   32'(a_cs),         32'd1);
        check({tag, "_sclk"}, 32'(a_sclk),       32'd0);
        check({tag, "_mosi"}, 32'(a_mosi),       32'd0);
        check({tag, "_dc"},   32'(a_dc),         32'd0);
        check({tag, "_done"}, 32'(ifa.wr_done),  32'd0);
        check({tag, "_busy"}, 32'(ifa.busy),     32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t0, fb, db, wb, sb, g;

        step_n(3);
        check_a_idle("reset");
        rst = 1'b0;
        step();

        // 1: command 0x3a
        fb = a_fall_cnt; db = a_done_cnt; wb = a_words.size();
        drv_data = 9'h03a; drv_en = 1'b1;
        a_wait_fall(fb, 10, "t1_start");
        t0 = a_starts[a_starts.size() - 1];
        drv_en = 1'b0;
        check("t1_dc", 32'(a_dc), 32'd0);
        a_wait_done(db, 60, "t1_done_seen");
        check("t1_done_time", 32'(a_done_cyc - t0), 32'd34);
        check("t1_cs_low",    32'(a_cs_rise_cyc - t0), 32'd34);
        check("t1_word",      32'(a_words[wb]), 32'h03a);
        check("t1_bits",      32'(a_bits[wb]), 32'd8);
        step();
        check("t1_done_pulse", 32'(ifa.wr_done), 32'd0);
        check("t1_busy_gap",   32'(ifa.busy), 32'd1);
        step();
        check("t1_busy_idle",  32'(ifa.busy), 32'd0);
        check("t1_done_count", 32'(a_done_cnt - db), 32'd1);

        // 2: data 0xa5
        fb = a_fall_cnt; db = a_done_cnt; wb = a_words.size();
        drv_data = 9'h1a5; drv_en = 1'b1;
        a_wait_fall(fb, 10, "t2_start");
        drv_en = 1'b0;
        check("t2_dc", 32'(a_dc), 32'd1);
        a_wait_done(db, 60, "t2_done_seen");
        check("t2_word",   32'(a_words[wb]), 32'h1a5);
        check("t2_bits",   32'(a_bits[wb]), 32'd8);
        check("t2_period", 32'(a_period), 32'd4);
        step();
        check("t2_cs_high", 32'(a_cs), 32'd1);
        step_n(3);

        // 3: upstream counter model, three words then en_write low
        fb = a_fall_cnt; db = a_done_cnt; wb = a_words.size(); sb = a_starts.size();
        up_mode = 1'b1;
        g = 0;
        while (a_done_cnt - db < 3 && g < 200) begin
            step();
            g++;
        end
        step_n(60);
        check("t3_words",   32'(a_fall_cnt - fb), 32'd3);
        check("t3_dones",   32'(a_done_cnt - db), 32'd3);
        check("t3_w0",      32'(a_words[wb]),     32'h011);
        check("t3_w1",      32'(a_words[wb + 1]), 32'h036);
        check("t3_w2",      32'(a_words[wb + 2]), 32'h100);
        check("t3_space01", 32'(a_starts[sb + 1] - a_starts[sb]),     32'd37);
        check("t3_space12", 32'(a_starts[sb + 2] - a_starts[sb + 1]), 32'd37);
        up_mode = 1'b0;
        step_n(2);

        // 4: inputs change mid-word
        fb = a_fall_cnt; db = a_done_cnt; wb = a_words.size();
        drv_data = 9'h0ff; drv_en = 1'b1;
        a_wait_fall(fb, 10, "t4_start");
        t0 = a_starts[a_starts.size() - 1];
        step_to(t0 + 5);
        drv_data = 9'h000; drv_en = 1'b0;
        a_wait_done(db, 60, "t4_done_seen");
        step_n(50);
        check("t4_word",  32'(a_words[wb]), 32'h0ff);
        check("t4_dones", 32'(a_done_cnt - db), 32'd1);
        check("t4_falls", 32'(a_fall_cnt - fb), 32'd1);
        check("t4_busy",  32'(ifa.busy), 32'd0);
        check("t4_cs",    32'(a_cs), 32'd1);

        // 5: reset mid-transfer, then a fresh word
        fb = a_fall_cnt; db = a_done_cnt;
        drv_data = 9'h1c3; drv_en = 1'b1;
        a_wait_fall(fb, 10, "t5_start");
        t0 = a_starts[a_starts.size() - 1];
        drv_en = 1'b0;
        step_to(t0 + 9);
        rst = 1'b1;
        step();
        check_a_idle("t5_abort");
        rst = 1'b0;
        step_n(40);
        check("t5_no_done", 32'(a_done_cnt - db), 32'd0);
        fb = a_fall_cnt; db = a_done_cnt; wb = a_words.size();
        drv_data = 9'h12c; drv_en = 1'b1;
        a_wait_fall(fb, 10, "t5b_start");
        drv_en = 1'b0;
        a_wait_done(db, 60, "t5b_done_seen");
        check("t5b_word", 32'(a_words[wb]), 32'h12c);
        check("t5b_bits", 32'(a_bits[wb]), 32'd8);
        check("dc_stable_under_cs", 32'(a_dc_moved), 32'd0);
        step_n(4);

        // 6: CLK_DIV=1 instance, en_write held high for two words
        b_data = 9'h055; b_en = 1'b1;
        g = 0;
        while (b_starts.size() == 0 && g < 10) begin
            step();
            g++;
        end
        check("t6_start", 32'(b_starts.size()), 32'd1);
        t0 = b_starts[0];
        b_data = 9'h0aa;
        g = 0;
        while (b_done_cnt == 0 && g < 40) begin
            step();
            g++;
        end
        check("t6_done_time", 32'(b_done_cyc - t0), 32'd17);
        check("t6_period",    32'(b_period), 32'd2);
        check("t6_byte0",     32'(b_bytes[0]), 32'h55);
        g = 0;
        while (b_starts.size() < 2 && g < 10) begin
            step();
            g++;
        end
        check("t6_next_latch", 32'(b_starts[1] - t0), 32'd20);
        b_en = 1'b0;
        g = 0;
        while (b_done_cnt < 2 && g < 40) begin
            step();
            g++;
        end
        check("t6_byte1", 32'(b_bytes[1]), 32'haa);
        step_n(30);
        check("t6_words", 32'(b_starts.size()), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
